// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 10-bit core: opcodes, function bits, field
// positions, descriptor op enum and loader status codes.
package cpu_isa_pkg;

    localparam int ISA_W  = 10;
    localparam int OP_MSB = 9;
    localparam int OP_LSB = 7;
    localparam int RA_MSB = 6;
    localparam int RA_LSB = 4;
    localparam int RB_MSB = 3;
    localparam int RB_LSB = 1;
    localparam int FN_BIT = 0;

    localparam logic [2:0] OPC_ALU  = 3'b000;
    localparam logic [2:0] OPC_MEM  = 3'b001;
    localparam logic [2:0] OPC_BR   = 3'b010;
    localparam logic [2:0] OPC_LOG  = 3'b011;
    localparam logic [2:0] OPC_LUHW = 3'b100;
    localparam logic [2:0] OPC_LLHW = 3'b101;
    localparam logic [2:0] OPC_IMM  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic FN_ADD  = 1'b0;
    localparam logic FN_SUB  = 1'b1;
    localparam logic FN_LW   = 1'b0;
    localparam logic FN_SW   = 1'b1;
    localparam logic FN_BGE  = 1'b0;
    localparam logic FN_BNE  = 1'b1;
    localparam logic FN_NOR  = 1'b0;
    localparam logic FN_SHL  = 1'b1;
    localparam logic FN_ADDI = 1'b0;
    localparam logic FN_J    = 1'b1;

    typedef enum logic [3:0] {
        D_ADD  = 4'd0,
        D_SUB  = 4'd1,
        D_LW   = 4'd2,
        D_SW   = 4'd3,
        D_BGE  = 4'd4,
        D_BNE  = 4'd5,
        D_NOR  = 4'd6,
        D_SHL  = 4'd7,
        D_LUHW = 4'd8,
        D_LLHW = 4'd9,
        D_ADDI = 4'd10,
        D_J    = 4'd11,
        D_HALT = 4'd12
    } desc_op_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_ILLEGAL_OP = 2'b01,
        ERR_BAD_REG    = 2'b10,
        ERR_OVERFLOW   = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } load_state_e;

    // Register-register format shared by all eight two-operand instructions.
    function automatic logic [ISA_W-1:0] pack_rr(input logic [2:0] opc,
                                                 input logic [2:0] ra,
                                                 input logic [2:0] rb,
                                                 input logic       fn);
        logic [ISA_W-1:0] w;
        w                 = '0;
        w[OP_MSB:OP_LSB]  = opc;
        w[RA_MSB:RA_LSB]  = ra;
        w[RB_MSB:RB_LSB]  = rb;
        w[FN_BIT]         = fn;
        return w;
    endfunction

endpackage

// File: rtl/isa_encoder.sv
// Combinational descriptor-to-ISA-word encoder; flags unknown ops and
// out-of-range register fields for the half-word load forms.
module isa_encoder
    import cpu_isa_pkg::*;
(
    input  logic [3:0]       i_op,
    input  logic [2:0]       i_ra,
    input  logic [2:0]       i_rb,
    input  logic [4:0]       i_imm,
    output logic [ISA_W-1:0] o_word,
    output logic             o_illegal,
    output logic             o_bad_reg,
    output logic             o_is_halt
);

    // NOTE: every output gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        o_bad_reg = 1'b0;
        o_is_halt = 1'b0;
        case (i_op)
            D_ADD:  o_word = pack_rr(OPC_ALU, i_ra, i_rb, FN_ADD);
            D_SUB:  o_word = pack_rr(OPC_ALU, i_ra, i_rb, FN_SUB);
            D_LW:   o_word = pack_rr(OPC_MEM, i_ra, i_rb, FN_LW);
            D_SW:   o_word = pack_rr(OPC_MEM, i_ra, i_rb, FN_SW);
            D_BGE:  o_word = pack_rr(OPC_BR,  i_ra, i_rb, FN_BGE);
            D_BNE:  o_word = pack_rr(OPC_BR,  i_ra, i_rb, FN_BNE);
            D_NOR:  o_word = pack_rr(OPC_LOG, i_ra, i_rb, FN_NOR);
            D_SHL:  o_word = pack_rr(OPC_LOG, i_ra, i_rb, FN_SHL);
            // Half-word loads only address r0..r3 through a 2-bit field.
            D_LUHW: begin
                o_word    = {OPC_LUHW, i_ra[1:0], i_imm};
                o_bad_reg = i_ra[2];
            end
            D_LLHW: begin
                o_word    = {OPC_LLHW, i_ra[1:0], i_imm};
                o_bad_reg = i_ra[2];
            end
            D_ADDI: o_word = {OPC_IMM, i_ra, i_imm[2:0], FN_ADDI};
            D_J:    o_word = {OPC_IMM, 6'b000000, FN_J};
            D_HALT: begin
                o_word    = {OPC_HALT, 7'b0000000};
                o_is_halt = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/prog_loader_encoder.sv
// Streams symbolic instruction descriptors into instruction memory, one
// encoded word per accepted descriptor, stopping on HALT, error or overflow.
module prog_loader_encoder
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_ra,
    input  logic [2:0]        in_rb,
    input  logic [4:0]        in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ISA_W-1:0]  imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    load_state_e       r_state;
    load_state_e       w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [ISA_W-1:0]  r_wdata;
    logic              r_done;
    logic              r_error;
    err_code_e         r_err_code;

    logic [ISA_W-1:0]  w_word;
    logic              w_illegal;
    logic              w_bad_reg;
    logic              w_is_halt;
    logic              w_accept;
    logic              w_last;

    isa_encoder u_isa_encoder (
        .i_op      (in_op),
        .i_ra      (in_ra),
        .i_rb      (in_rb),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal),
        .o_bad_reg (w_bad_reg),
        .o_is_halt (w_is_halt)
    );

    // start overrides a same-cycle handshake, dropping that descriptor.
    assign w_accept = in_valid & in_ready & ~start;
    assign w_last   = (r_ptr == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = (r_state == S_LOAD);
        if (start) begin
            w_next_state = S_LOAD;
        end else if (r_state == S_LOAD && w_accept) begin
            if (w_illegal || w_bad_reg) begin
                w_next_state = S_ERR;
            end else if (w_is_halt) begin
                w_next_state = S_DONE;
            end else if (w_last) begin
                w_next_state = S_ERR;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_ptr      <= '0;
                r_count    <= '0;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_err_code <= ERR_NONE;
            end else if (w_accept) begin
                if (w_illegal) begin
                    r_error    <= 1'b1;
                    r_err_code <= ERR_ILLEGAL_OP;
                end else if (w_bad_reg) begin
                    r_error    <= 1'b1;
                    r_err_code <= ERR_BAD_REG;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= r_ptr;
                    r_wdata <= w_word;
                    r_ptr   <= r_ptr + ADDR_W'(1);
                    r_count <= r_count + (ADDR_W + 1)'(1);
                    if (w_is_halt) begin
                        r_done <= 1'b1;
                    end else if (w_last) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_OVERFLOW;
                    end
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_prog_loader_encoder.sv
// Directed scoreboard bench for prog_loader_encoder with a 4-word memory so
// the overflow boundary is reachable with short programs.
module tb_prog_loader_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [3:0]        in_op    = '0;
    logic [2:0]        in_ra    = '0;
    logic [2:0]        in_rb    = '0;
    logic [4:0]        in_imm   = '0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [9:0]        imem_wdata;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    prog_loader_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [9:0]        wdata;
        logic              done;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'b%0b, expected 'b%0b", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] addr, input logic [9:0] wdata,
                                input logic dn);
        exp_t e;
        e.addr  = addr;
        e.wdata = wdata;
        e.done  = dn;
        sb_q.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic send(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [4:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_ra    = ra;
        in_rb    = rb;
        in_imm   = imm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (imem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 'b%0b, required no write",
                         imem_addr, imem_wdata);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", 32'(imem_wdata), 32'(e.wdata));
                check("wr_done", 32'(done), 32'(e.done));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset values
        #2;
        check("rst_we",       32'(imem_we),   0);
        check("rst_ready",    32'(in_ready),  0);
        check("rst_count",    32'(count),     0);
        check("rst_done",     32'(done),      0);
        check("rst_error",    32'(error),     0);
        check("rst_err_code", 32'(err_code),  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // IDLE ignores in_valid
        send(4'd0, 3'd3, 3'd1, 5'd0);
        idle(1);
        check("idle_count", 32'(count), 0);
        check("idle_ready", 32'(in_ready), 0);

        // Single ADD ra=3 rb=1
        pulse_start();
        check("load_ready", 32'(in_ready), 1);
        expect_write(0, 10'b0000110010, 1'b0);
        send(4'd0, 3'd3, 3'd1, 5'd0);
        check("add_we",    32'(imem_we), 1);
        check("add_count", 32'(count),   1);
        idle(1);

        // Back-to-back stream ending in HALT at the last address
        pulse_start();
        check("restart_count", 32'(count), 0);
        expect_write(0, 10'b1010001000, 1'b0);
        expect_write(1, 10'b1100011010, 1'b0);
        expect_write(2, 10'b1100000001, 1'b0);
        expect_write(3, 10'b1110000000, 1'b1);
        send(4'd9,  3'd0, 3'd0, 5'd8);
        send(4'd10, 3'd1, 3'd0, 5'd5);
        send(4'd11, 3'd0, 3'd0, 5'd0);
        send(4'd12, 3'd0, 3'd0, 5'd0);
        check("stream_done",  32'(done),     1);
        check("stream_error", 32'(error),    0);
        check("stream_ready", 32'(in_ready), 0);
        check("stream_count", 32'(count),    4);
        idle(2);
        check("done_sticky", 32'(done), 1);

        // Illegal op after one valid word, then recovery via start
        pulse_start();
        check("start_clr_done", 32'(done), 0);
        expect_write(0, 10'b0000010100, 1'b0);
        send(4'd0, 3'd1, 3'd2, 5'd0);
        send(4'd14, 3'd0, 3'd0, 5'd0);
        check("illop_error", 32'(error),    1);
        check("illop_code",  32'(err_code), 1);
        check("illop_ready", 32'(in_ready), 0);
        check("illop_count", 32'(count),    1);
        idle(1);
        pulse_start();
        check("clr_error", 32'(error),    0);
        check("clr_code",  32'(err_code), 0);
        check("clr_count", 32'(count),    0);
        expect_write(0, 10'b0001111111, 1'b0);
        send(4'd1, 3'd7, 3'd7, 5'd0);
        idle(1);

        // LUHW: legal ra=3, then ra=5 rejected
        pulse_start();
        expect_write(0, 10'b1001111111, 1'b0);
        send(4'd8, 3'd3, 3'd0, 5'd31);
        send(4'd8, 3'd5, 3'd0, 5'd3);
        check("badreg_error", 32'(error),    1);
        check("badreg_code",  32'(err_code), 2);
        check("badreg_count", 32'(count),    1);
        idle(1);

        // Overflow: four non-HALT words fill memory, fifth not accepted
        pulse_start();
        expect_write(0, 10'b0010101010, 1'b0);
        expect_write(1, 10'b0011001101, 1'b0);
        expect_write(2, 10'b0100010000, 1'b0);
        expect_write(3, 10'b0111100110, 1'b0);
        send(4'd2, 3'd2, 3'd5, 5'd0);
        send(4'd3, 3'd4, 3'd6, 5'd0);
        send(4'd4, 3'd1, 3'd0, 5'd0);
        send(4'd6, 3'd6, 3'd3, 5'd0);
        check("ovf_ready", 32'(in_ready), 0);
        send(4'd5, 3'd5, 3'd2, 5'd0);
        check("ovf_error", 32'(error),    1);
        check("ovf_code",  32'(err_code), 3);
        check("ovf_count", 32'(count),    4);
        check("ovf_done",  32'(done),     0);
        idle(1);

        // HALT as the fourth word lands on the last address and ends in DONE
        pulse_start();
        expect_write(0, 10'b0110000011, 1'b0);
        expect_write(1, 10'b0101010101, 1'b0);
        expect_write(2, 10'b1101110100, 1'b0);
        expect_write(3, 10'b1110000000, 1'b1);
        send(4'd7,  3'd0, 3'd1, 5'd0);
        send(4'd5,  3'd5, 3'd2, 5'd0);
        send(4'd10, 3'd7, 3'd0, 5'b11010);
        send(4'd12, 3'd7, 3'd7, 5'd31);
        check("halt_last_done",  32'(done),  1);
        check("halt_last_error", 32'(error), 0);
        check("halt_last_count", 32'(count), 4);
        idle(1);

        // Asynchronous reset while a write strobe is high
        pulse_start();
        send(4'd0, 3'd2, 3'd2, 5'd0);
        check("pre_rst_we", 32'(imem_we), 1);
        rst_n = 1'b0;
        #1;
        check("async_we",    32'(imem_we),  0);
        check("async_count", 32'(count),    0);
        check("async_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        idle(1);

        // start and handshake in the same cycle: descriptor dropped
        pulse_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_ra    = 3'd4;
        in_rb    = 3'd4;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        idle(2);
        check("drop_count", 32'(count),    0);
        check("drop_ready", 32'(in_ready), 1);

        idle(3);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader_encoder.md
Name: prog_loader_encoder

Overview:
Inverse of the instruction decoder. Accepts symbolic instruction descriptors (operation, register fields, immediate) over a valid/ready stream. Encodes each one into the 10-bit ISA word and writes it sequentially into instruction memory through a single write port. Used at boot or by the bench to load a program before releasing the CPU. Terminates on HALT, an illegal descriptor, or memory overflow.

Parameters:
ADDR_W, 8, instruction memory address width
DEPTH, 256, number of writable words (must be <= 2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; clears pointer and status, enters LOAD
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid & in_ready
in_op  in  4  operation code (enum below)
in_ra  in  3  first register field (rd/rs1)
in_rb  in  3  second register field (rs2)
in_imm  in  5  immediate (addi uses [2:0]; luhw/llhw use [4:0])
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  10  encoded instruction
count  out  ADDR_W+1  words written since start
done  out  1  sticky; HALT written
error  out  1  sticky; illegal descriptor or overflow
err_code  out  2  00 none, 01 illegal op, 10 bad luhw/llhw reg, 11 overflow

Behaviour:
- Reset: all outputs 0, state IDLE, pointer 0. Reset is asynchronous and active-low, so imem_we drops immediately even mid-write.
- States: IDLE, LOAD, DONE, ERR. in_ready=1 only in LOAD.
- start in any state: next cycle is LOAD, with pointer=0, count=0, done/error/err_code cleared, and any pending write cancelled.
- LOAD, on accept: the encoded word is registered. Next cycle imem_we=1, imem_addr=pointer, and imem_wdata=word. Pointer and count then increment. Latency is 1 cycle and throughput is 1 word/cycle. imem_we is high for exactly one cycle per word.
- Encoding. Fields: op[9:7], ra[6:4], rb[3:1], f[0]. Unused bits are 0.
  - ADD(0)=000,ra,rb,0 and SUB(1)=000,ra,rb,1
  - LW(2)=001,ra,rb,0 and SW(3)=001,ra,rb,1
  - BGE(4)=010,ra,rb,0 and BNE(5)=010,ra,rb,1
  - NOR(6)=011,ra,rb,0 and SHL(7)=011,ra,rb,1
  - LUHW(8)=100,ra[1:0],imm[4:0] and LLHW(9)=101,ra[1:0],imm[4:0]
  - ADDI(10)=110,ra,imm[2:0],0
  - J(11)=1100000001
  - HALT(12)=1110000000
- Illegal descriptors:
  - in_op 13..15: not written; go to ERR with err_code=01.
  - LUHW/LLHW with in_ra>3: not written; go to ERR with err_code=10.
- HALT accepted: the word is written normally, then go to DONE and assert done in the same cycle as its imem_we.
- Overflow: the descriptor that writes address DEPTH-1 is written. If it is not HALT, go to ERR with err_code=11 after that write. If it is HALT, go to DONE. No write is ever issued to an address >= DEPTH.
- DONE and ERR are sticky and hold in_ready=0 until start or reset. count holds its final value.
- start and an accept in the same cycle: start wins and the descriptor is dropped.
- In IDLE, in_valid is ignored.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode constants (OPC_ALU=000 ... OPC_HALT=111)
  - function-bit constants
  - the 4-bit descriptor op enum
  - ISA field bit positions
  - err_code constants
- The decoder is to be migrated onto the same package so both ends agree.
- One natural sub-module: isa_encoder. It is purely combinational, maps descriptor to {word, illegal, bad_reg}, and is reusable by the bench as a golden model. The FSM, pointer and output register stay in prog_loader_encoder.

Test Plan:
- Reset, start, then ADD ra=3 rb=1 -> one cycle later imem_we=1, addr=0, wdata=0000110010, count=1.
- Back-to-back stream LLHW ra=0 imm=8, ADDI ra=1 imm=5, J, HALT with in_valid held high -> four consecutive writes to addr 0..3 with wdata 1010001000, 1100011010, 1100000001, 1110000000. done=1 with the last write, then in_ready=0.
- in_op=14 after one valid word -> no second write, error=1, err_code=01. Then start -> error cleared, next word written to addr 0.
- LUHW ra=5 -> no write, err_code=10.
- DEPTH=4, five ADDs -> writes to addr 0..3, error=1, err_code=11, fifth not accepted. Repeat with HALT as the fourth descriptor -> done=1, error=0.
- Deassert rst_n while imem_we=1 mid-stream -> imem_we=0 asynchronously, state IDLE, count=0. Start and accept in the same cycle -> descriptor dropped, no write.
